cla_op_stream: RTL and testbench

Upstream issue/capture stage for the 5-bit CLA adder (`cla_adder_5bit`). It accepts operand pairs over a valid/ready stream and buffers them in an operand FIFO. It issues one pair per cycle to the adder's `a`/`b` inputs, tracks the adder's registered-output latency, and captures each `{cout,sum}` into a result FIFO presented as an in-order valid/ready output stream. This decouples producers and consumers from the adder, which has no stall capability.

---
 rtl/cla_stream_pkg.sv | 6 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/cla_op_stream.sv | 95 +++++++++
 tb/tb_cla_op_stream.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_stream_pkg.sv
// Shared constants and types for the CLA operand/result streaming wrapper.
package cla_stream_pkg;
  localparam int CLA_W   = 5;
  localparam int ADD_LAT = 2;
  typedef logic [CLA_W:0] cla_result_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; full when the MSBs differ and the rest match.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_wr, do_rd;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign count   = wptr_q - rptr_q;
  assign rd_data = mem_q[rptr_q[AW-1:0]];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/cla_op_stream.sv
// Issue/capture stage around a registered-output CLA adder: operand FIFO in,
// credit-limited issue, fixed-latency capture into an in-order result FIFO.
module cla_op_stream
  import cla_stream_pkg::*;
#(
  parameter int W      = CLA_W,
  parameter int DEPTH  = 4,
  parameter int RDEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_result,
  output logic         idle
);
  localparam int RAW = $clog2(RDEPTH);
  localparam int OW  = RAW + 2;

  logic [2*W-1:0]          op_head;
  logic                    op_full, op_empty;
  logic [$clog2(DEPTH):0]  op_count;
  logic [W:0]              res_head;
  logic                    res_full, res_empty;
  logic [RAW:0]            res_count;
  logic [ADD_LAT-1:0]      fl_q;
  logic [W-1:0]            add_a_q, add_b_q;
  logic [OW-1:0]           occ;
  logic                    issue, pop;

  assign in_ready = rst && !op_full;
  assign pop      = out_valid && out_ready;

  // Credit: results already held plus those still inside the adder must fit.
  always_comb begin
    occ = OW'(res_count);
    for (int i = 0; i < ADD_LAT; i++) occ = occ + OW'(fl_q[i]);
  end
  assign issue = !op_empty && (occ < OW'(RDEPTH));

  sync_fifo #(.WIDTH(2*W), .DEPTH(DEPTH)) u_op_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .wr_en  (in_valid && in_ready),
    .wr_data({in_a, in_b}),
    .rd_en  (issue),
    .rd_data(op_head),
    .full   (op_full),
    .empty  (op_empty),
    .count  (op_count)
  );

  sync_fifo #(.WIDTH(W+1), .DEPTH(RDEPTH)) u_res_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .wr_en  (fl_q[ADD_LAT-1]),
    .wr_data({add_cout, add_sum}),
    .rd_en  (pop),
    .rd_data(res_head),
    .full   (res_full),
    .empty  (res_empty),
    .count  (res_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_q    <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
    end else begin
      fl_q <= {fl_q[ADD_LAT-2:0], issue};
      if (issue) begin
        add_a_q <= op_head[2*W-1:W];
        add_b_q <= op_head[W-1:0];
      end
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign out_valid  = !res_empty;
  assign out_result = res_empty ? '0 : res_head;
  assign idle       = (op_count == '0) && !(|fl_q) && res_empty;

  a_no_res_overflow: assert property (@(posedge clk) disable iff (!rst)
    fl_q[ADD_LAT-1] |-> !res_full);
endmodule

// File: tb/tb_cla_op_stream.sv
// Randomised and directed bench for cla_op_stream with an in-bench adder model
// and a queue scoreboard of expected sums in acceptance order.
module tb_cla_op_stream;
  import cla_stream_pkg::*;
  localparam int W = CLA_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b, add_a, add_b, add_sum;
  logic         add_cout, out_valid, out_ready, idle;
  logic [W:0]   out_result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_first = -1;
  int pop_last  = 0;
  int pops      = 0;
  cla_result_t sb[$];

  cla_op_stream #(.W(W), .DEPTH(4), .RDEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Adder: one registered stage, reset active-high from ~rst.
  always @(posedge clk or posedge (~rst)) begin
    if (!rst) {add_cout, add_sum} <= '0;
    else      {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor at negedge: decisions here describe the next rising edge.
  always @(negedge clk) begin
    if (!rst) sb.delete();
    else begin
      chk("idle", {31'd0, idle}, {31'd0, sb.size() == 0});
      if (out_valid && sb.size() == 0) chk("phantom", {31'd0, out_valid}, 32'd0);
      else if (out_valid && out_ready) begin
        chk("result", {26'd0, out_result}, {26'd0, sb.pop_front()});
        pops++;
        pop_last = cyc + 1;
      end
      if (in_valid && in_ready) begin
        sb.push_back({1'b0, in_a} + {1'b0, in_b});
        if (acc_first < 0) acc_first = cyc + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int p0;
    logic rdy;
    rst = 1'b0; in_valid = 1'b1; in_a = 5'd3; in_b = 5'd4; out_ready = 1'b0;
    repeat (2) step();
    chk("rst in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst add_a",     {27'd0, add_a},     32'd0);
    chk("rst add_b",     {27'd0, add_b},     32'd0);
    chk("rst idle",      {31'd0, idle},      32'd1);
    chk("rst out_result",{26'd0, out_result},32'd0);
    rst = 1'b1; in_valid = 1'b0; #1;
    chk("rel in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel idle",     {31'd0, idle},     32'd1);

    // Single op: 31 + 1 -> carry out, latency 3
    in_a = 5'd31; in_b = 5'd1; in_valid = 1'b1; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    step();
    chk("single add_a", {27'd0, add_a}, 32'd31);
    chk("single add_b", {27'd0, add_b}, 32'd1);
    chk("single ov e1", {31'd0, out_valid}, 32'd0);
    step();
    chk("single ov e2", {31'd0, out_valid}, 32'd0);
    step();
    chk("single ov e3", {31'd0, out_valid}, 32'd1);
    chk("single res",   {26'd0, out_result}, 32'd32);
    chk("single busy",  {31'd0, idle}, 32'd0);
    step();
    chk("single idle",  {31'd0, idle}, 32'd1);
    chk("single ov e4", {31'd0, out_valid}, 32'd0);

    // Exhaustive back-to-back stream
    acc_first = -1; pops = 0;
    for (int k = 0; k < 1024; k++) begin
      in_valid = 1'b1; in_a = k[9:5]; in_b = k[4:0];
      chk("exh in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 20 && sb.size() > 0; t++) step();
    chk("exh drained", sb.size(), 32'd0);
    chk("exh pops", pops, 32'd1024);
    chk("exh span", pop_last - acc_first, 32'd1027);

    // Backpressure: 10 pairs (i, 2i) offered, out_ready low
    step();
    out_ready = 1'b0; idx = 0; pops = 0;
    for (int c = 0; c < 16; c++) begin
      if (idx < 10) begin in_valid = 1'b1; in_a = W'(idx); in_b = W'(2*idx); end
      else in_valid = 1'b0;
      rdy = in_ready;
      step();
      if (rdy && in_valid) idx++;
    end
    chk("bp accepted", idx, 32'd8);
    chk("bp in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp head",     {26'd0, out_result}, 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 10 || sb.size() > 0); c++) begin
      if (idx < 10) begin in_valid = 1'b1; in_a = W'(idx); in_b = W'(2*idx); end
      else in_valid = 1'b0;
      rdy = in_ready;
      step();
      if (rdy && in_valid) idx++;
    end
    in_valid = 1'b0;
    chk("bp all accepted", idx, 32'd10);
    chk("bp pops", pops, 32'd10);

    // Same-edge capture and pop with two results held
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 5'd1; in_b = 5'd2; step();
    in_a = 5'd3; in_b = 5'd4; step();
    in_a = 5'd5; in_b = 5'd6; step();
    in_valid = 1'b0;
    step(); step();
    chk("sim head0", {26'd0, out_result}, 32'd3);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("sim head1", {26'd0, out_result}, 32'd7);
    step();
    chk("sim hold",  {26'd0, out_result}, 32'd7);
    out_ready = 1'b1; step();
    chk("sim head2", {26'd0, out_result}, 32'd11);
    step();
    chk("sim empty", {31'd0, out_valid}, 32'd0);
    chk("sim idle",  {31'd0, idle}, 32'd1);

    // Random traffic
    pops = 0; p0 = 0;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_a = W'($urandom); in_b = W'($urandom);
      if (in_valid && in_ready) p0++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 30 && sb.size() > 0; t++) step();
    chk("rand drained", sb.size(), 32'd0);

    // Reset while busy
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_a = W'(c + 9); in_b = W'(c + 17); step();
    end
    rst = 1'b0; #1;
    chk("mid in_ready",  {31'd0, in_ready},  32'd0);
    chk("mid out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid add_a",     {27'd0, add_a},     32'd0);
    chk("mid result",    {26'd0, out_result},32'd0);
    chk("mid idle",      {31'd0, idle},      32'd1);
    step(); step();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("post ov", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1; in_a = 5'd20; in_b = 5'd22; step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("post res", {26'd0, out_result}, 32'd42);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
